// File: rtl/logic_op_scheduler.sv
// Time-shared bit-serial AND/OR/XOR/XNOR engine with a round-robin arbiter across NREQ requesters.
// Evaluates one result bit per clock, LSB first, then holds the tagged result until the consumer accepts it.
module logic_op_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NREQ-1:0]             req_valid_i,
    input  logic [2*NREQ-1:0]           req_op_i,
    input  logic [WIDTH*NREQ-1:0]       req_a_i,
    input  logic [WIDTH*NREQ-1:0]       req_b_i,
    output logic [NREQ-1:0]             req_ready_o,
    output logic                        rsp_valid_o,
    output logic [$clog2(NREQ)-1:0]     rsp_id_o,
    output logic [WIDTH-1:0]            rsp_data_o,
    input  logic                        rsp_ready_i,
    output logic                        busy_o
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;
    localparam int unsigned SW  = IDW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic [2*NREQ-1:0] dbl_c;
    logic [NREQ-1:0]   rot_c;
    logic [SW-1:0]     sum_c;
    logic              found_c;
    logic [IDW-1:0]    win_c;
    logic              accept_c;
    logic [1:0]        op_sel_c;
    logic [WIDTH-1:0]  a_sel_c, b_sel_c;
    logic [WIDTH-1:0]  a_sh_c, b_sh_c;
    logic              bit_c;

    // Round-robin winner: rotate so last_grant+1 lands at bit 0, then take the first set bit.
    always_comb begin
        dbl_c   = {req_valid_i, req_valid_i} >> ({1'b0, last_q} + SW'(1));
        rot_c   = dbl_c[NREQ-1:0];
        found_c = 1'b0;
        win_c   = '0;
        sum_c   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found_c && rot_c[0]) begin
                found_c = 1'b1;
                sum_c   = {1'b0, last_q} + SW'(1) + SW'(k);
                if (sum_c >= SW'(NREQ)) begin
                    sum_c = sum_c - SW'(NREQ);
                end
                win_c = IDW'(sum_c);
            end
            rot_c = rot_c >> 1;
        end
    end

    always_comb begin
        op_sel_c = 2'(req_op_i >> {win_c, 1'b0});
        a_sel_c  = WIDTH'(req_a_i >> (WIDTH * win_c));
        b_sel_c  = WIDTH'(req_b_i >> (WIDTH * win_c));
    end

    // Shared 1-bit evaluation stage.
    always_comb begin
        a_sh_c = a_q >> cnt_q;
        b_sh_c = b_q >> cnt_q;
        unique case (op_q)
            2'b00:   bit_c = a_sh_c[0] & b_sh_c[0];
            2'b01:   bit_c = a_sh_c[0] | b_sh_c[0];
            2'b10:   bit_c = a_sh_c[0] ^ b_sh_c[0];
            default: bit_c = ~(a_sh_c[0] ^ b_sh_c[0]);
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept_c) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(WIDTH - 1)) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Grant is combinational from state and req_valid only; rsp_ready never reaches it.
    always_comb begin
        req_ready_o = '0;
        accept_c    = 1'b0;
        if (rst_ni && (state_q == S_IDLE) && found_c) begin
            req_ready_o = NREQ'(1) << win_c;
            accept_c    = 1'b1;
        end
    end

    always_comb begin
        last_d   = last_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (accept_c) begin
            last_d   = win_c;
            id_d     = win_c;
            op_d     = op_sel_c;
            a_d      = a_sel_c;
            b_d      = b_sel_c;
            cnt_d    = '0;
            result_d = '0;
        end else if (state_q == S_RUN) begin
            result_d = result_q | (WIDTH'(bit_c) << cnt_q);
            cnt_d    = cnt_q + CW'(1);
        end
        rsp_valid_d = (state_d == S_RESP);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            last_q      <= last_d;
            id_q        <= id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = result_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler: results, latency, arbitration order, back-pressure and reset.
module tb_logic_op_scheduler;
    localparam int W = 8;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [2*N-1:0]   req_op;
    logic [W*N-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_data;
    logic             rsp_ready;
    logic             busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int gnt_id[$];
    int gnt_cyc[$];

    logic_op_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .rsp_ready_i(rsp_ready), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Grant log: which requester transferred, and on which cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gnt_id.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_op[2*id +: 2] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
    endtask

    task automatic wait_rsp(input string tag, input int id, input logic [7:0] exp);
        int n;
        n = 0;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(rsp_valid), 1);
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || rsp_valid) && n < 60) begin
            step();
            n++;
        end
        check_eq({tag, "_idle"}, 32'(busy), 0);
    endtask

    // One op from one requester; checks grant, one-cycle ready, latency, result and release.
    task automatic run_op(input string tag, input int id, input logic [1:0] op,
                          input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        int n;
        @(negedge clk);
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            step();
            n++;
        end
        check_eq({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        check_eq({tag, "_ready_drop"}, 32'(req_ready), 0);
        check_eq({tag, "_busy"}, 32'(busy), 1);
        n = 1;
        while (!rsp_valid && n < 30) begin
            step();
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 9);
        check_eq({tag, "_id"}, 32'(rsp_id), 32'(id));
        check_eq({tag, "_data"}, 32'(rsp_data), 32'(exp));
        if (rsp_ready) begin
            step();
            check_eq({tag, "_rsp_done"}, 32'(rsp_valid), 0);
            check_eq({tag, "_busy_done"}, 32'(busy), 0);
        end
    endtask

    // Hold a set of requests until n grants have been logged, then withdraw them.
    task automatic hold_until(input logic [N-1:0] mask, input int ngr);
        int n;
        gnt_id.delete();
        gnt_cyc.delete();
        @(negedge clk);
        req_valid = mask;
        n = 0;
        while (gnt_id.size() < ngr && n < 200) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        #1;
    endtask

    initial begin
        int order[6];
        int cnt;
        order = '{0, 1, 2, 3, 0, 1};
        rst_n     = 1'b0;
        req_valid = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset: everything quiet, ready forced low even with requests pending.
        repeat (3) step();
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_valid", 32'(rsp_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_data", 32'(rsp_data), 0);
        check_eq("rst_id", 32'(rsp_id), 0);
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;

        run_op("and0", 0, 2'b00, 8'hF0, 8'h3C, 8'h30);
        run_op("xor2", 2, 2'b10, 8'hA5, 8'hFF, 8'h5A);
        run_op("or2", 2, 2'b01, 8'h81, 8'h18, 8'h99);
        run_op("xnor2", 2, 2'b11, 8'h0F, 8'h33, 8'hC3);

        // After serving 2, requesters 1 and 3 contend: 3 wins first.
        set_req(1, 2'b00, 8'hFF, 8'h11);
        set_req(3, 2'b00, 8'hFF, 8'h22);
        hold_until(4'b1010, 2);
        wait_idle("rr13");
        check_eq("rr13_n", 32'(gnt_id.size()), 2);
        check_eq("rr13_first", 32'(gnt_id[0]), 3);
        check_eq("rr13_second", 32'(gnt_id[1]), 1);

        // Back-pressure: result held for 5 cycles, no grant while in RESP.
        rsp_ready = 1'b0;
        run_op("stall", 2, 2'b10, 8'h12, 8'h34, 8'h26);
        set_req(0, 2'b00, 8'hFF, 8'h0F);
        req_valid[0] = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(rsp_valid), 1);
            check_eq("stall_data", 32'(rsp_data), 32'h26);
            check_eq("stall_id", 32'(rsp_id), 2);
            check_eq("stall_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("stall_rel_ready", 32'(req_ready), 0);
        check_eq("stall_rel_valid", 32'(rsp_valid), 1);
        step();
        check_eq("stall_idle_valid", 32'(rsp_valid), 0);
        check_eq("stall_idle_busy", 32'(busy), 0);
        check_eq("stall_idle_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_rsp("stall_next", 0, 8'h0F);
        wait_idle("stall_next");

        // Reset mid-RUN at bit_cnt 3: op dropped, arbiter pointer back to NREQ-1.
        @(negedge clk);
        set_req(1, 2'b01, 8'h55, 8'hAA);
        req_valid[1] = 1'b1;
        #1;
        check_eq("mid_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_busy", 32'(busy), 0);
        check_eq("mid_valid", 32'(rsp_valid), 0);
        check_eq("mid_data", 32'(rsp_data), 0);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) cnt++;
            step();
        end
        check_eq("mid_no_rsp", 32'(cnt), 0);
        set_req(0, 2'b10, 8'h0F, 8'hFF);
        set_req(3, 2'b00, 8'hFF, 8'hFF);
        req_valid = 4'b1001;
        #1;
        check_eq("mid_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        wait_rsp("mid_next", 0, 8'hF0);
        wait_idle("mid_next");

        // Fresh reset, then all four contend continuously.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 2'b01, 8'(i), 8'h80);
        hold_until(4'b1111, 6);
        wait_idle("rr4");
        check_eq("rr4_n", 32'(gnt_id.size()), 6);
        for (int i = 0; i < 6 && i < gnt_id.size(); i++) begin
            check_eq($sformatf("rr4_id%0d", i), 32'(gnt_id[i]), 32'(order[i]));
            if (i > 0) check_eq($sformatf("rr4_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/logic_op_scheduler.md
# logic_op_scheduler

Time-shared, bit-serial bitwise logic engine for up to NREQ requesters. Owns one 1-bit AND/OR/XOR/XNOR evaluation stage. A round-robin arbiter grants one requester at a time and latches its operands. The block then walks the operand bits LSB-first through the shared stage, one bit per clock, and returns the WIDTH-bit result tagged with the requester index. Sits between the gate-level logic primitives and any client blocks that need bitwise ops without a dedicated parallel datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- NREQ, 4, number of requesters (2..8); IDW = clog2(NREQ)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  bit i: requester i has an op pending
- req_op  in  2*NREQ  slice [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 XNOR
- req_a  in  WIDTH*NREQ  slice i: operand A
- req_b  in  WIDTH*NREQ  slice i: operand B
- req_ready  out  NREQ  one-hot accept, combinational from state and req_valid
- rsp_valid  out  1  result available
- rsp_id  out  IDW  index of the requester that owns rsp_data
- rsp_data  out  WIDTH  result
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in RUN or RESP

## Operation
- States: IDLE, RUN, RESP.
- **IDLE**
  - Winner = first i with req_valid[i], scanning last_grant+1, last_grant+2, … and wrapping modulo NREQ.
  - req_ready[winner] = 1; all other bits 0.
  - Transfer on a clock edge where req_valid[i] & req_ready[i].
  - On transfer: latch op, A and B; rsp_id <= winner; last_grant <= winner; bit_cnt <= 0; result <= 0; go to RUN.
  - No req_valid: stay in IDLE; req_ready = 0.
- **RUN**
  - Each cycle, bit k = bit_cnt is computed from A[k], B[k] and op.
  - result[k] <= f(A[k], B[k]) and bit_cnt <= bit_cnt + 1.
  - bit_cnt is clog2(WIDTH)+1 bits wide and never wraps.
  - When bit_cnt == WIDTH-1: write the last bit and go to RESP.
  - req_ready = 0 in all bits.
- **RESP**
  - rsp_valid = 1; rsp_data = result; rsp_id is held.
  - rsp_data and rsp_id stay stable until rsp_valid & rsp_ready; then go to IDLE.
  - req_ready = 0.
- Requester protocol: req_valid, req_op, req_a and req_b are held stable from assertion until accepted. If req_valid drops before grant, no op is issued; this is not an error.
- Latched operands are independent of req_* after transfer; requesters may change inputs freely during RUN/RESP.
- Simultaneous requests are resolved by round-robin only; no requester is starved. Worst-case wait is (NREQ-1) ops.
- Reset (rst_n low at an edge, in any state, including mid-RUN):
  - state IDLE, last_grant = NREQ-1, bit_cnt 0, result 0.
  - rsp_valid 0, rsp_data 0, rsp_id 0, busy 0.
  - Any in-flight op is dropped with no response.
  - req_ready forced 0 while rst_n is low.

## Timing
- Accept edge T (end of the IDLE cycle with ready high). RUN occupies the cycles after T through T+WIDTH.
- rsp_valid rises in cycle T+WIDTH+1 (WIDTH+1 cycles after the accept edge).
- With rsp_ready held high:
  - RESP lasts 1 cycle.
  - IDLE lasts at least 1 cycle.
  - Issue-to-issue spacing = WIDTH+2 cycles (10 for WIDTH=8).
- busy is registered: high from cycle T+1 until the cycle after the response handshake.
- req_ready and winner selection are combinational in IDLE only. There is no combinational path from rsp_ready to req_ready in the same cycle.

## Test plan
- Reset, then req 0 AND A=0xF0, B=0x3C → req_ready = 0001 for one cycle; rsp_valid 9 cycles after accept; rsp_data 0x30, rsp_id 0.
- Req 2 sequentially:
  - XOR 0xA5/0xFF → 0x5A
  - OR 0x81/0x18 → 0x99
  - XNOR 0x0F/0x33 → 0xC3
  - all with rsp_id 2.
- All four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0,1; each exactly 10 cycles apart.
- rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; no req_ready pulse; IDLE entered the cycle after rsp_ready rises.
- rst_n low for 1 cycle while bit_cnt=3 → no rsp_valid; busy 0; next request from reqs {0,3} grants 0.
- After serving req 2, reqs 1 and 3 valid → 3 granted first, then 1.
